input_debouncer: RTL
====================

# input_debouncer

Conditions the two raw push-button/switch inputs before they reach the AND gate stage that consumes signals `a` and `b`. Each channel is double-flop synchronised into the `clk` domain and then debounced. A level change is accepted only after it has been stable for `STABLE_CYCLES` consecutive cycles. The block outputs clean levels, which drive the gate's `a`/`b` inputs directly, plus one-cycle edge pulses for downstream counters and LEDs.

## Interface
- `N_CH`, default 2: number of independent channels (channel 0 feeds `a`, channel 1 feeds `b`).
- `CNT_W`, default 20: width of the per-channel stability counter.
- `STABLE_CYCLES`, default 1_000_000: required stable cycles (10 ms at 100 MHz). Legal range is 1 to 2^CNT_W − 1; otherwise elaboration must fail.
- `clk`  in  1: the single system clock; all logic on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `raw_in`  in  N_CH: asynchronous raw inputs.
- `clean_out`  out  N_CH: debounced levels.
- `rise_pulse`  out  N_CH: one-cycle high when the corresponding `clean_out` goes 0→1.
- `fall_pulse`  out  N_CH: one-cycle high when the corresponding `clean_out` goes 1→0.

## Operation
- Per channel, `raw_in` passes through `sync1` → `sync2`. This path has no logic and is the only path from `raw_in`.
- Each channel has a two-state FSM:
  - STABLE: `sync2 == clean_out`; counter held at 0. On `sync2 != clean_out`, go to CHANGING with counter ← 1. If `STABLE_CYCLES == 1`, instead commit immediately (see below).
  - CHANGING: while `sync2 != clean_out` and counter < `STABLE_CYCLES`, counter increments each cycle. When counter reaches `STABLE_CYCLES` and mismatch persists: `clean_out` ← `sync2`, counter ← 0, return to STABLE. If `sync2 == clean_out` at any cycle (glitch ended), counter ← 0 and return to STABLE with no output change.
- Edge pulses:
  - Registered; asserted on the same edge that `clean_out` toggles, deasserted next cycle.
  - `rise_pulse` and `fall_pulse` are never both high on one channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous, independent pulses.
- Counter never exceeds `STABLE_CYCLES`; no wrap-around is possible.

## Timing
- Reset (`rst_n` low at a rising edge):
  - `sync1`, `sync2`, `clean_out`, `rise_pulse`, `fall_pulse` ← 0; counters ← 0; FSM ← STABLE.
  - Reset mid-count discards progress.
  - No pulse is generated by reset itself, including when `clean_out` was 1.
- First edge with `rst_n` high resumes normal operation. A `raw_in` already at 1 during reset is debounced normally and yields a `rise_pulse`.
- Latency: a `raw_in` level first sampled by `sync1` at edge k, held stable, appears on `clean_out` at edge k + 1 + `STABLE_CYCLES` (2 sync stages + `STABLE_CYCLES` count).
- Rejection:
  - A mismatch lasting fewer than `STABLE_CYCLES` cycles at `sync2` never changes `clean_out`.
  - A bounce resets the count fully; the count restarts from the next mismatch.
- Outputs are all registered; no combinational path from `raw_in` to any output.

## Structure
- Package `debounce_pkg`:
  - enum `db_state_t` {DB_STABLE, DB_CHANGING}.
  - constant `DB_DEFAULT_STABLE` = 1_000_000.
  - constant `DB_DEFAULT_CNT_W` = 20.
- Sub-module `debounce_ch` (one channel: sync pair, counter, FSM, pulse regs), parameterised by `CNT_W` and `STABLE_CYCLES`.
- `input_debouncer` instantiates `debounce_ch` `N_CH` times in a generate loop and concatenates outputs.

## Test plan
Bench uses `STABLE_CYCLES`=4, `CNT_W`=4, `N_CH`=2.
- Reset, both `raw_in`=0: hold `rst_n`=0 for 3 cycles → all outputs 0. Release → outputs stay 0 with no pulses for 20 cycles.
- Clean rise on ch0: `raw_in[0]` 0→1 sampled at edge k → `clean_out[0]`=1 at edge k+5; `rise_pulse[0]` high exactly one cycle at k+5; ch1 untouched.
- Bounce rejection: `raw_in[0]` toggles 1,0,1,0 one cycle each, then rests at 0 → `clean_out[0]` stays 0 and no pulses. Then hold 1 → rises 5 edges after the final 0→1 sample.
- Clean fall with simultaneous channels: both channels at 1, both drop at edge k → both `clean_out`=0 and both `fall_pulse` high at edge k+5 for one cycle; `rise_pulse`=0 throughout.
- Reset mid-operation: `raw_in[1]`=1 for 3 cycles, then `rst_n`=0 for 1 cycle with `raw_in[1]` still 1 → no pulse and `clean_out[1]`=0 during reset. After release the count restarts: `clean_out[1]`=1 exactly 5 edges after the first post-reset `sync1` sample.
- Gate integration: connect `clean_out[0]`/`[1]` to the AND gate. Raise ch0, then ch1 three cycles later → gate output goes high 5 edges after the ch1 sample, never earlier.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button / switch debouncer.
// The defaults give 10 ms of required stability at a 100 MHz clock.
package debounce_pkg;

    typedef enum logic [0:0] {
        DB_STABLE   = 1'b0,
        DB_CHANGING = 1'b1
    } db_state_t;

    localparam int DB_DEFAULT_STABLE = 1_000_000;
    localparam int DB_DEFAULT_CNT_W  = 20;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, STABLE/CHANGING FSM, edge pulse regs.
// Latency raw->clean is 1 + STABLE_CYCLES edges after sync1 samples; no backpressure, all outputs registered.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int CNT_W         = DB_DEFAULT_CNT_W,
    parameter int STABLE_CYCLES = DB_DEFAULT_STABLE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam longint MAX_STABLE = (longint'(1) << CNT_W) - 1;

    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > MAX_STABLE) begin : g_bad_param
        $error("debounce_ch: STABLE_CYCLES must lie in 1 .. 2**CNT_W-1");
    end

    // The commit happens on the edge where the count would reach STABLE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mismatch;
    logic             commit;

    assign mismatch = (sync2_q != clean_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            DB_STABLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    if (STABLE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = DB_CHANGING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DB_CHANGING: begin
                if (!mismatch) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
        clean_d = commit ? sync2_q : clean_q;
        rise_d  = commit & sync2_q;
        fall_d  = commit & ~sync2_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// N_CH independent debounce channels; channel 0 drives gate input a, channel 1 drives b.
// Latency 1 + STABLE_CYCLES edges after the first sync sample; no backpressure.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int CNT_W         = DB_DEFAULT_CNT_W,
    parameter int STABLE_CYCLES = DB_DEFAULT_STABLE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .raw_i  (raw_in[i]),
            .clean_o(clean_out[i]),
            .rise_o (rise_pulse[i]),
            .fall_o (fall_pulse[i])
        );
    end

endmodule
